// File: rtl/cache_mem_arbiter_pkg.sv
// Shared state encoding, grant constants and latency bounds for cache_mem_arbiter.
package cache_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } arb_state_e;

  localparam logic GntI = 1'b0;
  localparam logic GntD = 1'b1;

  localparam int unsigned LatencyMin = 1;
  localparam int unsigned LatencyMax = 255;
  localparam int unsigned LatCntW    = $clog2(LatencyMax + 1);

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-request round-robin picker; last_grant starts at D so the icache wins the first tie.
module cache_mem_arbiter_rr_arb2
  import cache_mem_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i_i,
  input  logic req_d_i,
  input  logic upd_i,
  input  logic upd_gnt_i,
  output logic gnt_o
);

  logic last_q, last_d;

  always_comb begin
    last_d = upd_i ? upd_gnt_i : last_q;
    if (req_i_i && req_d_i) begin
      gnt_o = ~last_q;
    end else if (req_d_i) begin
      gnt_o = GntD;
    end else begin
      gnt_o = GntI;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= GntD;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache refills and dcache reads/writes onto one single-port RAM with a fixed
// access latency. Define ARB_PERF_CNT_EN to add access and stall counters.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned RAM_AW  = 12,
  parameter int unsigned LATENCY = 3
) (
  input  logic              cpu_clk,
  input  logic              rstn,
  input  logic              i_r_mem,
  input  logic [31:0]       i_mem_addr,
  output logic [31:0]       i_mem_r_data,
  output logic              i_mem_ready,
  input  logic              d_r_mem,
  input  logic              d_w_mem,
  input  logic [31:0]       d_mem_addr,
  input  logic [31:0]       d_mem_w_data,
  output logic [31:0]       d_mem_r_data,
  output logic              d_mem_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       i_acc_cnt,
  output logic [31:0]       d_acc_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  // Out-of-range LATENCY is clamped into the legal window.
  localparam int unsigned LatClamped = (LATENCY < LatencyMin) ? LatencyMin :
                                       (LATENCY > LatencyMax) ? LatencyMax : LATENCY;
  localparam logic [LatCntW-1:0] CntLoad = LatCntW'(LatClamped - 1);

  arb_state_e          state_q, state_d;
  logic [LatCntW-1:0]  cnt_q, cnt_d;
  logic                gnt_q, gnt_d;
  logic                we_op_q, we_op_d;
  logic [RAM_AW-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                i_rdy_q, i_rdy_d;
  logic                d_rdy_q, d_rdy_d;
  logic                ram_we_q, ram_we_d;
  logic                d_req;
  logic                arb_gnt;
  logic                in_resp;
  logic                unused_addr_bits;

  assign d_req   = d_r_mem | d_w_mem;
  assign in_resp = (state_q == StResp);
  assign unused_addr_bits = ^{i_mem_addr[31:RAM_AW+2], i_mem_addr[1:0],
                              d_mem_addr[31:RAM_AW+2], d_mem_addr[1:0]};

  cache_mem_arbiter_rr_arb2 u_rr_arb2 (
    .clk_i     (cpu_clk),
    .rst_ni    (rstn),
    .req_i_i   (i_r_mem),
    .req_d_i   (d_req),
    .upd_i     (in_resp),
    .upd_gnt_i (gnt_q),
    .gnt_o     (arb_gnt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    we_op_d  = we_op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    i_rdy_d  = 1'b0;
    d_rdy_d  = 1'b0;
    ram_we_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_r_mem || d_req) begin
          gnt_d   = arb_gnt;
          we_op_d = (arb_gnt == GntD) && d_w_mem;
          addr_d  = (arb_gnt == GntD) ? d_mem_addr[RAM_AW+1:2] : i_mem_addr[RAM_AW+1:2];
          if ((arb_gnt == GntD) && d_w_mem) begin
            wdata_d = d_mem_w_data;
          end
          cnt_d   = CntLoad;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          // Completion flags are registered here so they are clean for the whole RESP cycle.
          state_d  = StResp;
          i_rdy_d  = (gnt_q == GntI);
          d_rdy_d  = (gnt_q == GntD);
          ram_we_d = we_op_q;
        end else begin
          cnt_d = cnt_q - LatCntW'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      gnt_q    <= GntI;
      we_op_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      i_rdy_q  <= 1'b0;
      d_rdy_q  <= 1'b0;
      ram_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      we_op_q  <= we_op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      i_rdy_q  <= i_rdy_d;
      d_rdy_q  <= d_rdy_d;
      ram_we_q <= ram_we_d;
    end
  end

  assign ram_addr     = addr_q;
  assign ram_we       = ram_we_q;
  assign ram_wdata    = wdata_q;
  assign i_mem_ready  = i_rdy_q;
  assign d_mem_ready  = d_rdy_q;
  assign i_mem_r_data = i_rdy_q ? ram_rdata : '0;
  assign d_mem_r_data = d_rdy_q ? ram_rdata : '0;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] i_acc_q, i_acc_d;
  logic [31:0] d_acc_q, d_acc_d;
  logic [31:0] stall_q, stall_d;
  logic        other_waiting;

  always_comb begin
    other_waiting = (gnt_q == GntI) ? d_req : i_r_mem;
    i_acc_d = i_acc_q;
    d_acc_d = d_acc_q;
    stall_d = stall_q;
    if (in_resp) begin
      if (gnt_q == GntI) begin
        i_acc_d = i_acc_q + 32'd1;
      end else begin
        d_acc_d = d_acc_q + 32'd1;
      end
    end
    // A stall is the lost IDLE tie plus every WAIT cycle spent behind the other port.
    if (((state_q == StIdle) && i_r_mem && d_req) || ((state_q == StWait) && other_waiting)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge cpu_clk or negedge rstn) begin
    if (!rstn) begin
      i_acc_q <= '0;
      d_acc_q <= '0;
      stall_q <= '0;
    end else begin
      i_acc_q <= i_acc_d;
      d_acc_q <= d_acc_d;
      stall_q <= stall_d;
    end
  end

  assign i_acc_cnt = i_acc_q;
  assign d_acc_cnt = d_acc_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: timestamp-based transaction model plus directed
// scenarios with literal expectations. Counter checks are built when ARB_PERF_CNT_EN is defined.
module tb_cache_mem_arbiter;

  localparam int unsigned L  = 3;
  localparam int unsigned AW = 12;

  logic          cpu_clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_r_mem = 1'b0, d_r_mem = 1'b0, d_w_mem = 1'b0;
  logic [31:0]   i_mem_addr = '0, d_mem_addr = '0, d_mem_w_data = '0;
  logic [31:0]   i_mem_r_data, d_mem_r_data, ram_wdata, ram_rdata;
  logic          i_mem_ready, d_mem_ready, ram_we;
  logic [AW-1:0] ram_addr;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   i_acc_cnt, d_acc_cnt, stall_cnt;
`endif

  cache_mem_arbiter #(.RAM_AW(AW), .LATENCY(L)) dut (
    .cpu_clk      (cpu_clk),
    .rstn         (rstn),
    .i_r_mem      (i_r_mem),
    .i_mem_addr   (i_mem_addr),
    .i_mem_r_data (i_mem_r_data),
    .i_mem_ready  (i_mem_ready),
    .d_r_mem      (d_r_mem),
    .d_w_mem      (d_w_mem),
    .d_mem_addr   (d_mem_addr),
    .d_mem_w_data (d_mem_w_data),
    .d_mem_r_data (d_mem_r_data),
    .d_mem_ready  (d_mem_ready),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
`ifdef ARB_PERF_CNT_EN
    ,
    .i_acc_cnt    (i_acc_cnt),
    .d_acc_cnt    (d_acc_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int k = 0;  // index of the current clock interval
  always @(posedge cpu_clk) k <= k + 1;

  // Synchronous RAM behind the arbiter, plus the bench's own reference copy.
  logic [31:0] tb_ram  [2**AW];
  logic [31:0] ref_mem [2**AW];
  always @(posedge cpu_clk) begin
    if (ram_we) tb_ram[ram_addr] <= ram_wdata;
    ram_rdata <= tb_ram[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (interval %0d)", name, got, exp, k);
    end
  endtask

  // Model: one outstanding access, granted in interval g_k, completing at g_k+L+1.
  bit            act = 1'b0, m_wr = 1'b0, m_port_d = 1'b0, last_d_m = 1'b1, fin;
  int            g_k = 0, done_k = 0, idle_from = 0;
  logic [AW-1:0] m_word = '0;
  logic [31:0]   m_wdata = '0;

  always @(negedge cpu_clk) begin
    if (!rstn) begin
      check("rst_i_ready", i_mem_ready, 0);
      check("rst_d_ready", d_mem_ready, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_i_rdata", i_mem_r_data, 0);
      check("rst_d_rdata", d_mem_r_data, 0);
      act = 1'b0; last_d_m = 1'b1; idle_from = 0;
    end else begin
      fin = act && (k == done_k);
      check("i_ready", i_mem_ready, fin && !m_port_d);
      check("d_ready", d_mem_ready, fin && m_port_d);
      check("ram_we", ram_we, fin && m_wr);
      if (act && k > g_k) check("ram_addr", ram_addr, m_word);
      if (fin) begin
        if (m_wr) check("ram_wdata", ram_wdata, m_wdata);
        else if (m_port_d) check("d_rdata", d_mem_r_data, ref_mem[m_word]);
        else check("i_rdata", i_mem_r_data, ref_mem[m_word]);
        if (m_port_d) check("i_rdata_quiet", i_mem_r_data, 0);
        else check("d_rdata_quiet", d_mem_r_data, 0);
        if (m_wr) ref_mem[m_word] = m_wdata;
        last_d_m = m_port_d; act = 1'b0; idle_from = k + 1;
      end
      if (!act && k >= idle_from && (i_r_mem || d_r_mem || d_w_mem)) begin
        m_port_d = (i_r_mem && (d_r_mem || d_w_mem)) ? !last_d_m : !i_r_mem;
        m_wr     = m_port_d && d_w_mem;
        m_word   = m_port_d ? d_mem_addr[AW+1:2] : i_mem_addr[AW+1:2];
        m_wdata  = d_mem_w_data;
        act = 1'b1; g_k = k; done_k = k + L + 1;
      end
    end
  end

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; i_r_mem = 1'b0; d_r_mem = 1'b0; d_w_mem = 1'b0;
    step(); step();
    rstn = 1'b1;
  endtask

  // Bounded wait for one port's ready; at_k stays -1 when the bound expires.
  task automatic await(input bit want_d, input int max_cyc, output int at_k, output int we_cnt,
                       output int oth, output logic [31:0] data);
    at_k = -1; we_cnt = 0; oth = 0; data = '0;
    for (int c = 0; c < max_cyc; c++) begin
      step();
      if (ram_we) we_cnt++;
      if (want_d ? i_mem_ready : d_mem_ready) oth++;
      if (want_d ? d_mem_ready : i_mem_ready) begin
        at_k = k;
        data = want_d ? d_mem_r_data : i_mem_r_data;
        break;
      end
    end
  endtask

  int          t0, at, wc, oth, n, wide, ti, td, rst_we;
  logic [31:0] dat;
  logic [3:0]  order;
  bit          prev_rdy;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      tb_ram[i] = '0; ref_mem[i] = '0;
    end
    tb_ram[12'h010]  = 32'hDEADBEEF;
    ref_mem[12'h010] = 32'hDEADBEEF;

    // Reset state, then a single icache read of word 0x10.
    repeat (3) step();
    check("reset_ram_addr", ram_addr, 0);
    check("reset_i_ready", i_mem_ready, 0);
    rstn = 1'b1;
    step();
    i_r_mem = 1'b1; i_mem_addr = 32'h40; t0 = k;
    await(1'b0, 12, at, wc, oth, dat);
    i_r_mem = 1'b0;
    check("t1_latency", at - t0, L + 1);
    check("t1_data", dat, 32'hDEADBEEF);
    check("t1_no_d_ready", oth, 0);

    // Write then read back through the data port.
    step();
    d_w_mem = 1'b1; d_mem_addr = 32'h80; d_mem_w_data = 32'h12345678; t0 = k;
    await(1'b1, 12, at, wc, oth, dat);
    d_w_mem = 1'b0;
    check("t2_wr_latency", at - t0, L + 1);
    check("t2_we_pulses", wc, 1);
    step();
    d_r_mem = 1'b1;
    await(1'b1, 12, at, wc, oth, dat);
    d_r_mem = 1'b0;
    check("t2_rd_data", dat, 32'h12345678);
    check("t2_rd_no_we", wc, 0);

    // Both ports held continuously from reset: I,D,I,D with single-cycle pulses.
    do_reset();
    i_r_mem = 1'b1; d_r_mem = 1'b1; i_mem_addr = 32'h40; d_mem_addr = 32'h80; t0 = k;
    n = 0; wide = 0; order = '0; prev_rdy = 1'b0; at = -1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      step();
      if ((i_mem_ready || d_mem_ready) && prev_rdy) wide++;
      prev_rdy = i_mem_ready || d_mem_ready;
      if (i_mem_ready) begin order = {order[2:0], 1'b0}; n++; at = k; end
      if (d_mem_ready) begin order = {order[2:0], 1'b1}; n++; at = k; end
    end
    i_r_mem = 1'b0; d_r_mem = 1'b0;
    check("t3_pulses", n, 4);
    check("t3_order", order, 4'b0101);
    check("t3_wide", wide, 0);
    check("t3_last_at", at - t0, 4 * (L + 2) - 1);

    // D request arriving during the icache WAIT is served after RESP plus one IDLE.
    step();
    i_r_mem = 1'b1; i_mem_addr = 32'h44; t0 = k;
    step(); step();
    d_r_mem = 1'b1; d_mem_addr = 32'h80;
    ti = -1; td = -1; dat = '0;
    for (int c = 0; c < 20 && td < 0; c++) begin
      step();
      if (i_mem_ready) begin ti = k; i_r_mem = 1'b0; end
      if (d_mem_ready) begin td = k; dat = d_mem_r_data; d_r_mem = 1'b0; end
    end
    check("t4_i_at", ti - t0, L + 1);
    check("t4_d_at", td - t0, 2 * L + 3);
    check("t4_d_data", dat, 32'h12345678);

    // Read and write asserted together is a write.
    step();
    d_r_mem = 1'b1; d_w_mem = 1'b1; d_mem_addr = 32'h88; d_mem_w_data = 32'hA5A55A5A;
    await(1'b1, 12, at, wc, oth, dat);
    d_r_mem = 1'b0; d_w_mem = 1'b0;
    check("t5_we_pulses", wc, 1);
    step();
    d_r_mem = 1'b1;
    await(1'b1, 12, at, wc, oth, dat);
    d_r_mem = 1'b0;
    check("t5_rd_data", dat, 32'hA5A55A5A);

    // Reset in the WAIT of a write: no write reaches the RAM, next access is normal.
    step();
    d_w_mem = 1'b1; d_mem_addr = 32'h84; d_mem_w_data = 32'hCAFEF00D;
    step(); step();
    rstn = 1'b0;
    #1;
    check("t6_rst_we", ram_we, 0);
    check("t6_rst_addr", ram_addr, 0);
    check("t6_rst_d_ready", d_mem_ready, 0);
    d_w_mem = 1'b0;
    rst_we = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (ram_we) rst_we++;
    end
    rstn = 1'b1;
    step();
    d_r_mem = 1'b1; d_mem_addr = 32'h84; t0 = k;
    await(1'b1, 12, at, wc, oth, dat);
    d_r_mem = 1'b0;
    check("t6_no_we", rst_we + wc, 0);
    check("t6_latency", at - t0, L + 1);
    check("t6_data", dat, 32'h0);

`ifdef ARB_PERF_CNT_EN
    // Three I reads and two D reads, the first pair colliding.
    do_reset();
    check("t7_cnt_reset", stall_cnt, 0);
    i_r_mem = 1'b1; d_r_mem = 1'b1; i_mem_addr = 32'h40; d_mem_addr = 32'h80;
    td = -1;
    for (int c = 0; c < 30 && td < 0; c++) begin
      step();
      if (i_mem_ready) i_r_mem = 1'b0;
      if (d_mem_ready) begin td = k; d_r_mem = 1'b0; end
    end
    for (int r = 0; r < 3; r++) begin
      step();
      if (r < 2) begin
        i_r_mem = 1'b1;
        await(1'b0, 12, at, wc, oth, dat);
        i_r_mem = 1'b0;
      end else begin
        d_r_mem = 1'b1;
        await(1'b1, 12, at, wc, oth, dat);
        d_r_mem = 1'b0;
      end
    end
    step();
    check("t7_i_acc", i_acc_cnt, 3);
    check("t7_d_acc", d_acc_cnt, 2);
    check("t7_stall", stall_cnt, L + 1);
`endif

    step(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
